aggregation_reader: RTL and testbench
=====================================

Name: aggregation_reader

Overview:
- Consumer of the forAggregation flag (word 0x002) that the sink-detection stage sets in shared data memory.
- When started, it reads the flag. If the flag is set, it reads a neighbour-value count and that many value words, and sums them with saturation.
- It writes the sum and the count used back to memory, clears the flag, and signals done.
- It uses the same en/start/done sequencing and the same single-port memory master interface as the other node-processing stages.

Parameters:
- VAL_BASE, 11'h010, address of the first neighbour-value word.
- MAX_VALUES, 16, upper clamp on the number of value words read (1..1024).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- en  input  1  re-arm: in WAIT_EN, clears outputs and moves to IDLE.
- start  input  1  begin one pass; sampled only in IDLE.
- data_in  input  16  memory read data; valid on the first rising edge after address is driven.
- address  output  11  memory address.
- wr_en  output  1  memory write strobe; a write occurs on each edge where it is high.
- data_out  output  16  memory write data.
- aggregate  output  16  saturated sum from the last pass; 0 if no aggregation was done.
- agg_valid  output  1  high if the last pass found the flag set and wrote results.
- done  output  1  pass complete; held high until en.

Behaviour:
- Memory map:
  - 0x002 forAggregation flag.
  - 0x003 value count N.
  - 0x004 sum result.
  - 0x005 count used.
  - VAL_BASE..VAL_BASE+N-1 values.
- Reset (nrst=0 at an edge):
  - address=0x002, wr_en=0, data_out=0, aggregate=0, agg_valid=0, done=0.
  - Internal sum and counters cleared; state=WAIT_EN.
  - Reset during any state, including mid-write, aborts the pass on that edge. No further writes occur.
- WAIT_EN: if en, clear done, agg_valid, aggregate, wr_en and the sum; address=0x002; go to IDLE. Otherwise hold.
- IDLE: if start, address=0x002 and go to CHK_FLAG. Otherwise hold.
- CHK_FLAG:
  - Sample data_in.
  - If data_in==16'h0001, address=0x003 and go to LOAD_CNT.
  - Any other value: agg_valid=0, go to FINISH. No writes occur.
- LOAD_CNT:
  - cnt = min(data_in, MAX_VALUES), stored in count-used.
  - If cnt==0, go to WR_SUM with sum=0.
  - Otherwise address=VAL_BASE, idx=0, go to ACC.
- ACC:
  - sum = sum + data_in, unsigned, computed 17 bits wide and saturated to 16'hFFFF.
  - idx++, address++.
  - When idx reaches cnt, go to WR_SUM.
  - address never exceeds VAL_BASE+cnt-1 while reading. The 11-bit address wraps modulo 2048.
- WR_SUM: address=0x004, data_out=sum, wr_en=1.
- WR_CNT: address=0x005, data_out=cnt, wr_en=1.
- CLR_FLAG: address=0x002, data_out=0, wr_en=1.
- WR_END: wr_en=0, aggregate=sum, agg_valid=1, go to FINISH.
- FINISH: done=1, go to WAIT_EN.
- Latency, with edge 0 = the edge sampling start:
  - Flag clear: done visible after edge 2.
  - Flag set: done visible after edge N+7, where N is the clamped count. Writes are asserted after edges N+3..N+5, i.e. 3 consecutive single-cycle writes.
- Handshakes and illegal states:
  - start outside IDLE is ignored.
  - en outside WAIT_EN is ignored.
  - en and start high together in WAIT_EN: only en acts; start must be re-sampled in IDLE.
  - Undefined state encoding goes to WAIT_EN.
- wr_en is never high in any state other than WR_SUM, WR_CNT and CLR_FLAG.

Test Plan:
- Reset then en, start with mem[0x002]=0: no wr_en at any point; done=1 after edge 2; aggregate=0, agg_valid=0; done holds until en.
- mem[0x002]=1, N=3, values 5,7,9:
  - mem[0x004]=21, mem[0x005]=3, mem[0x002]=0.
  - aggregate=21, agg_valid=1, done after edge 10.
  - Exactly 3 writes.
- mem[0x002]=1, N=2, values 0xFFF0,0x0020: sum saturates; mem[0x004]=0xFFFF, aggregate=0xFFFF.
- mem[0x002]=1, N=40, MAX_VALUES=16: only addresses 0x010..0x01F read; mem[0x005]=16. mem[0x002]=1, N=0: mem[0x004]=0, mem[0x005]=0, flag cleared.
- nrst low during ACC of an N=5 pass: no writes, outputs at reset values. Subsequent en+start with mem[0x002]=2 (not 1) gives done, no writes.
- start pulsed in WAIT_EN and FINISH: ignored. en+start together in WAIT_EN: IDLE reached; pass begins only on a later start.

Source files
------------

// File: rtl/aggregation_reader_if.sv
// Single-port data memory bus shared by the node-processing stages.
//   data_in  : read data, valid on the first rising edge after address is driven
//   address  : 11-bit word address
//   wr_en    : write strobe, one write per rising edge while high
//   data_out : write data
// master = the stage driving the memory, slave = the memory model.
interface aggregation_reader_if;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;

  modport master (input data_in, output address, output wr_en, output data_out);
  modport slave (output data_in, input address, input wr_en, input data_out);
endinterface

// File: rtl/aggregation_reader.sv
// Consumes the forAggregation flag (word 0x002). When started and the flag is 1, reads the
// neighbour-value count (0x003, clamped to MAX_VALUES) and that many words from VAL_BASE,
// sums them with 16-bit saturation, writes the sum (0x004) and count used (0x005), clears
// the flag and raises done. done holds until en re-arms the block.
// Ports:
//   clock, nrst        : clock, synchronous active-low reset
//   en, start          : re-arm (WAIT_EN only) / begin a pass (IDLE only)
//   mem                : memory master port (data_in, address, wr_en, data_out)
//   aggregate          : saturated sum of the last pass, 0 if no aggregation done
//   agg_valid          : last pass found the flag set and wrote results
//   done               : pass complete
module aggregation_reader #(
  parameter logic [10:0] VAL_BASE   = 11'h010,
  parameter int unsigned MAX_VALUES = 16
) (
  input  logic                        clock,
  input  logic                        nrst,
  input  logic                        en,
  input  logic                        start,
  aggregation_reader_if.master        mem,
  output logic [15:0]                 aggregate,
  output logic                        agg_valid,
  output logic                        done
);

  localparam logic [10:0] AddrFlag = 11'h002;
  localparam logic [10:0] AddrCnt  = 11'h003;
  localparam logic [10:0] AddrSum  = 11'h004;
  localparam logic [10:0] AddrUsed = 11'h005;
  localparam logic [15:0] MaxCnt   = 16'(MAX_VALUES);

  typedef enum logic [3:0] {
    StWaitEn, StIdle, StChkFlag, StLoadCnt, StAcc,
    StWrSum, StWrCnt, StClrFlag, StWrEnd, StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] address_q, address_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] data_out_q, data_out_d;
  logic [15:0] aggregate_q, aggregate_d;
  logic        agg_valid_q, agg_valid_d;
  logic        done_q, done_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [16:0] sum_ext;
  logic [15:0] cnt_clamped;
  logic        last_read;

  assign sum_ext     = {1'b0, sum_q} + {1'b0, mem.data_in};
  assign cnt_clamped = (mem.data_in > MaxCnt) ? MaxCnt : mem.data_in;
  assign last_read   = (idx_q + 16'd1) == cnt_q;

  // State register
  always_ff @(posedge clock) begin
    if (!nrst) state_q <= StWaitEn;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWaitEn:  if (en) state_d = StIdle;
      StIdle:    if (start) state_d = StChkFlag;
      StChkFlag: state_d = (mem.data_in == 16'h0001) ? StLoadCnt : StFinish;
      StLoadCnt: state_d = (cnt_clamped == 16'd0) ? StWrSum : StAcc;
      StAcc:     if (last_read) state_d = StWrSum;
      StWrSum:   state_d = StWrCnt;
      StWrCnt:   state_d = StClrFlag;
      StClrFlag: state_d = StWrEnd;
      StWrEnd:   state_d = StFinish;
      StFinish:  state_d = StWaitEn;
      default:   state_d = StWaitEn;
    endcase
  end

  // Output and datapath next values; all outputs are registered
  always_comb begin
    address_d   = address_q;
    wr_en_d     = 1'b0;
    data_out_d  = data_out_q;
    aggregate_d = aggregate_q;
    agg_valid_d = agg_valid_q;
    done_d      = done_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    case (state_q)
      StWaitEn: begin
        if (en) begin
          done_d      = 1'b0;
          agg_valid_d = 1'b0;
          aggregate_d = 16'd0;
          sum_d       = 16'd0;
          address_d   = AddrFlag;
        end
      end
      StIdle:    if (start) address_d = AddrFlag;
      StChkFlag: begin
        if (mem.data_in == 16'h0001) address_d = AddrCnt;
        else                         agg_valid_d = 1'b0;
      end
      StLoadCnt: begin
        cnt_d = cnt_clamped;
        sum_d = 16'd0;
        idx_d = 16'd0;
        if (cnt_clamped != 16'd0) address_d = VAL_BASE;
      end
      StAcc: begin
        sum_d = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
        idx_d = idx_q + 16'd1;
        // Hold on the last word so the read window never runs past VAL_BASE+cnt-1
        if (!last_read) address_d = address_q + 11'd1;
      end
      StWrSum: begin
        address_d  = AddrSum;
        data_out_d = sum_q;
        wr_en_d    = 1'b1;
      end
      StWrCnt: begin
        address_d  = AddrUsed;
        data_out_d = cnt_q;
        wr_en_d    = 1'b1;
      end
      StClrFlag: begin
        address_d  = AddrFlag;
        data_out_d = 16'd0;
        wr_en_d    = 1'b1;
      end
      StWrEnd: begin
        aggregate_d = sum_q;
        agg_valid_d = 1'b1;
      end
      StFinish: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      address_q   <= AddrFlag;
      wr_en_q     <= 1'b0;
      data_out_q  <= 16'd0;
      aggregate_q <= 16'd0;
      agg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= 16'd0;
      cnt_q       <= 16'd0;
      idx_q       <= 16'd0;
    end else begin
      address_q   <= address_d;
      wr_en_q     <= wr_en_d;
      data_out_q  <= data_out_d;
      aggregate_q <= aggregate_d;
      agg_valid_q <= agg_valid_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
    end
  end

  assign mem.address  = address_q;
  assign mem.wr_en    = wr_en_q;
  assign mem.data_out = data_out_q;
  assign aggregate    = aggregate_q;
  assign agg_valid    = agg_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_aggregation_reader.sv
// Bench for aggregation_reader: table of passes with hand-computed results, plus
// sequences for reset mid-pass and the en/start handshake corner cases.
module tb_aggregation_reader;
  localparam logic [10:0] VAL_BASE = 11'h010;
  localparam logic [15:0] SENT     = 16'hDEAD;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        en    = 1'b0;
  logic        start = 1'b0;
  logic [15:0] aggregate;
  logic        agg_valid;
  logic        done;

  aggregation_reader_if bus ();

  aggregation_reader #(.VAL_BASE(VAL_BASE), .MAX_VALUES(16)) dut (
    .clock     (clock),
    .nrst      (nrst),
    .en        (en),
    .start     (start),
    .mem       (bus.master),
    .aggregate (aggregate),
    .agg_valid (agg_valid),
    .done      (done)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [2048];
  assign bus.data_in = mem[bus.address];

  int          checks   = 0;
  int          failures = 0;
  int          writes   = 0;
  logic [10:0] max_addr = 11'd0;

  typedef struct {
    logic [15:0] flag, n, v0, v1, v2, fill;
    logic [15:0] exp_sum, exp_cnt;
    logic        exp_valid;
    int          exp_done, exp_writes;
    logic [10:0] exp_maxa;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Outputs are registered, so a write strobe seen mid-cycle is committed here
  task automatic tick();
    @(negedge clock);
    if (bus.wr_en) begin
      mem[bus.address] = bus.data_out;
      writes++;
    end else if (bus.address >= VAL_BASE && bus.address > max_addr) begin
      max_addr = bus.address;
    end
  endtask

  task automatic load(input vec_t v);
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    mem[2] = v.flag;
    mem[3] = v.n;
    mem[4] = SENT;
    mem[5] = SENT;
    for (int a = 16; a < 64; a++) mem[a] = v.fill;
    mem[16] = v.v0;
    mem[17] = v.v1;
    mem[18] = v.v2;
  endtask

  task automatic arm();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Starts a pass from IDLE and checks it against the vector
  task automatic go(input vec_t v, input string nm);
    int got;
    writes   = 0;
    max_addr = 11'd0;
    got      = -1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin
        got = i;
        break;
      end
    end
    chk({nm, "_done_edge"}, got, v.exp_done);
    chk({nm, "_aggregate"}, aggregate, v.exp_valid ? v.exp_sum : 16'd0);
    chk({nm, "_agg_valid"}, agg_valid, v.exp_valid);
    chk({nm, "_mem_flag"}, mem[2], v.exp_valid ? 16'd0 : v.flag);
    chk({nm, "_mem_sum"}, mem[4], v.exp_valid ? v.exp_sum : SENT);
    chk({nm, "_mem_cnt"}, mem[5], v.exp_valid ? v.exp_cnt : SENT);
    chk({nm, "_max_read_addr"}, max_addr, v.exp_maxa);
    for (int i = 0; i < 3; i++) tick();
    chk({nm, "_done_hold"}, done, 1'b1);
    chk({nm, "_writes"}, writes, v.exp_writes);
  endtask

  initial begin
    //          flag    n       v0       v1       v2     fill   sum      cnt    val  done wr  maxa
    vecs[0] = '{16'd0, 16'd3,  16'd5,   16'd7,   16'd9, 16'd0, 16'd0,   16'd0,  1'b0, 2,  0, 11'h000};
    vecs[1] = '{16'd1, 16'd3,  16'd5,   16'd7,   16'd9, 16'd0, 16'd21,  16'd3,  1'b1, 10, 3, 11'h012};
    vecs[2] = '{16'd1, 16'd2,  16'hFFF0, 16'h0020, 16'd0, 16'd0, 16'hFFFF, 16'd2, 1'b1, 9, 3, 11'h011};
    vecs[3] = '{16'd1, 16'd40, 16'd1,   16'd1,   16'd1, 16'd1, 16'd16,  16'd16, 1'b1, 23, 3, 11'h01F};
    vecs[4] = '{16'd1, 16'd0,  16'd5,   16'd7,   16'd9, 16'd4, 16'd0,   16'd0,  1'b1, 7,  3, 11'h000};
    vecs[5] = '{16'd2, 16'd3,  16'd5,   16'd7,   16'd9, 16'd0, 16'd0,   16'd0,  1'b0, 2,  0, 11'h000};

    load(vecs[0]);
    tick();
    tick();
    nrst = 1'b1;
    chk("rst_address", bus.address, 11'h002);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_data_out", bus.data_out, 16'd0);
    chk("rst_aggregate", aggregate, 16'd0);
    chk("rst_agg_valid", agg_valid, 1'b0);
    chk("rst_done", done, 1'b0);

    foreach (vecs[k]) begin
      load(vecs[k]);
      arm();
      go(vecs[k], $sformatf("v%0d", k));
    end

    // Reset during ACC of an N=5 pass aborts it with no writes
    load('{16'd1, 16'd5, 16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0, 1'b0, 0, 0, 11'h0});
    arm();
    writes = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("midrst_address", bus.address, 11'h002);
    chk("midrst_wr_en", bus.wr_en, 1'b0);
    chk("midrst_data_out", bus.data_out, 16'd0);
    chk("midrst_aggregate", aggregate, 16'd0);
    chk("midrst_agg_valid", agg_valid, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_writes", writes, 0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_flag_kept", mem[2], 16'd1);
    load(vecs[5]);
    arm();
    go(vecs[5], "after_rst");

    // start in WAIT_EN is ignored even with the flag set
    load(vecs[1]);
    writes = 0;
    start  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("start_waiten_writes", writes, 0);
    chk("start_waiten_done", done, 1'b1);

    // start held through FINISH and WAIT_EN is ignored
    load(vecs[0]);
    arm();
    writes = 0;
    start  = 1'b1;
    tick();
    tick();
    mem[2] = 16'd1;
    for (int i = 0; i < 6; i++) tick();
    start = 1'b0;
    tick();
    chk("start_finish_writes", writes, 0);
    chk("start_finish_done", done, 1'b1);

    // en+start together only re-arms; the pass waits for a later start
    load(vecs[1]);
    writes = 0;
    en     = 1'b1;
    start  = 1'b1;
    tick();
    en    = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("en_start_writes", writes, 0);
    chk("en_start_done", done, 1'b0);
    chk("en_start_flag_kept", mem[2], 16'd1);
    go(vecs[1], "en_start_pass");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
